// File: rtl/smc_lite_pkg10.sv
// Shared types and helpers for the lite SMC read path: FSM states, memory
// width encodings and beat/lane arithmetic.
package smc_lite_pkg10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } rd_state_e;

    localparam logic [1:0] MW_8  = 2'b00;
    localparam logic [1:0] MW_16 = 2'b01;
    localparam logic [1:0] MW_32 = 2'b10;

    function automatic logic [2:0] beats_per_word(input logic [1:0] mw);
        case (mw)
            MW_8:    return 3'd4;
            MW_16:   return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    // Byte address driven to memory for a given beat of the current width.
    function automatic logic [1:0] lane_offset(input logic [1:0] mw, input logic [1:0] beat);
        case (mw)
            MW_8:    return beat;
            MW_16:   return {beat[0], 1'b0};
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/smc_rd_pack10.sv
// Merges one narrow beat from the external bus into the partially assembled
// 32-bit read word (little-endian lane placement).
module smc_rd_pack10
    import smc_lite_pkg10::*;
(
    input  logic [1:0]  mw,
    input  logic [1:0]  beat,
    input  logic [31:0] data_smc10,
    input  logic [31:0] cur_word,
    output logic [31:0] next_word
);

    always_comb begin
        next_word = cur_word;
        case (mw)
            MW_8:    next_word[{beat, 3'b000} +: 8]     = data_smc10[7:0];
            MW_16:   next_word[{beat[0], 4'b0000} +: 16] = data_smc10[15:0];
            default: next_word = data_smc10;
        endcase
    end

endmodule

// File: rtl/smc_rd_enable_lite10.sv
// Read strobe sequencer for the lite SMC: drives active-low OE through
// setup/strobe/hold per beat and assembles narrow beats into a 32-bit word.
module smc_rd_enable_lite10
    import smc_lite_pkg10::*;
#(
    parameter int WS_W = 4
) (
    input  logic            sys_clk10,
    input  logic            sys_reset10,
    input  logic            rd_start10,
    input  logic            rd_abort10,
    input  logic [1:0]      r_mw10,
    input  logic [1:0]      r_oe_setup10,
    input  logic [WS_W-1:0] r_rd_wait10,
    input  logic [1:0]      r_oe_hold10,
    input  logic [31:0]     data_smc10,
    output logic            smc_n_oe10,
    output logic [1:0]      smc_addr_lsb10,
    output logic [31:0]     rd_data10,
    output logic            rd_valid10,
    output logic            rd_busy10
);

    rd_state_e       state;
    logic [WS_W-1:0] cnt;
    logic [1:0]      beat;
    logic [1:0]      mw_q;
    logic [1:0]      setup_q;
    logic [WS_W-1:0] wait_q;
    logic [1:0]      hold_q;

    logic [WS_W-1:0] wait_eff;
    logic [31:0]     packed_word;
    logic            last_beat;

    // Decisions taken when a beat finishes (end of STROBE with no hold, or end of HOLD).
    rd_state_e       ab_state;
    logic [WS_W-1:0] ab_cnt;
    logic [1:0]      ab_beat;
    logic [1:0]      ab_addr;
    logic            ab_n_oe;
    logic            ab_busy;

    assign wait_eff  = (r_rd_wait10 == '0) ? WS_W'(1) : r_rd_wait10;
    assign last_beat = ({1'b0, beat} == (beats_per_word(mw_q) - 3'd1));

    smc_rd_pack10 u_pack (
        .mw         (mw_q),
        .beat       (beat),
        .data_smc10 (data_smc10),
        .cur_word   (rd_data10),
        .next_word  (packed_word)
    );

    always_comb begin
        ab_state = ST_IDLE;
        ab_cnt   = '0;
        ab_beat  = beat;
        ab_addr  = 2'd0;
        ab_n_oe  = 1'b1;
        ab_busy  = 1'b0;
        if (!last_beat) begin
            ab_beat = beat + 2'd1;
            ab_addr = lane_offset(mw_q, beat + 2'd1);
            ab_busy = 1'b1;
            if (setup_q != 2'd0) begin
                ab_state = ST_SETUP;
                ab_cnt   = WS_W'(setup_q) - 1'b1;
            end else begin
                ab_state = ST_STROBE;
                ab_cnt   = wait_q - 1'b1;
                ab_n_oe  = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk10) begin
        if (sys_reset10) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            beat           <= 2'd0;
            mw_q           <= MW_8;
            setup_q        <= 2'd0;
            wait_q         <= WS_W'(1);
            hold_q         <= 2'd0;
            smc_n_oe10     <= 1'b1;
            smc_addr_lsb10 <= 2'd0;
            rd_data10      <= 32'd0;
            rd_valid10     <= 1'b0;
            rd_busy10      <= 1'b0;
        end else begin
            rd_valid10 <= 1'b0;
            if (state == ST_IDLE) begin
                if (rd_start10) begin
                    mw_q           <= r_mw10;
                    setup_q        <= r_oe_setup10;
                    wait_q         <= wait_eff;
                    hold_q         <= r_oe_hold10;
                    beat           <= 2'd0;
                    rd_data10      <= 32'd0;
                    smc_addr_lsb10 <= 2'd0;
                    rd_busy10      <= 1'b1;
                    if (r_oe_setup10 != 2'd0) begin
                        state <= ST_SETUP;
                        cnt   <= WS_W'(r_oe_setup10) - 1'b1;
                    end else begin
                        state      <= ST_STROBE;
                        cnt        <= wait_eff - 1'b1;
                        smc_n_oe10 <= 1'b0;
                    end
                end
            end else if (rd_abort10) begin
                // Abort takes priority over any capture due this cycle.
                state          <= ST_IDLE;
                smc_n_oe10     <= 1'b1;
                smc_addr_lsb10 <= 2'd0;
                rd_busy10      <= 1'b0;
            end else begin
                case (state)
                    ST_SETUP: begin
                        if (cnt == '0) begin
                            state      <= ST_STROBE;
                            cnt        <= wait_q - 1'b1;
                            smc_n_oe10 <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_STROBE: begin
                        if (cnt == '0) begin
                            rd_data10  <= packed_word;
                            rd_valid10 <= last_beat;
                            if (hold_q != 2'd0) begin
                                state      <= ST_HOLD;
                                cnt        <= WS_W'(hold_q) - 1'b1;
                                smc_n_oe10 <= 1'b1;
                            end else begin
                                state          <= ab_state;
                                cnt            <= ab_cnt;
                                beat           <= ab_beat;
                                smc_addr_lsb10 <= ab_addr;
                                smc_n_oe10     <= ab_n_oe;
                                rd_busy10      <= ab_busy;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (cnt == '0) begin
                            state          <= ab_state;
                            cnt            <= ab_cnt;
                            beat           <= ab_beat;
                            smc_addr_lsb10 <= ab_addr;
                            smc_n_oe10     <= ab_n_oe;
                            rd_busy10      <= ab_busy;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_smc_rd_enable_lite10.sv
// Bench for smc_rd_enable_lite10: directed reads with a queue-based scoreboard
// for completed words plus cycle-exact strobe/address/busy checks.
module tb_smc_rd_enable_lite10;

    localparam int WS_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd_start;
    logic            rd_abort;
    logic [1:0]      r_mw;
    logic [1:0]      r_setup;
    logic [WS_W-1:0] r_wait;
    logic [1:0]      r_hold;
    logic [31:0]     data_smc;
    logic            n_oe;
    logic [1:0]      addr_lsb;
    logic [31:0]     rd_data;
    logic            rd_valid;
    logic            rd_busy;

    logic [31:0] mem [4];
    logic [31:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    logic oe_e2   [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] ad_e2 [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    always #5 clk = ~clk;

    // Simple memory model: the bus reflects the word at the beat's byte address.
    assign data_smc = mem[addr_lsb];

    smc_rd_enable_lite10 #(.WS_W(WS_W)) dut (
        .sys_clk10      (clk),
        .sys_reset10    (rst),
        .rd_start10     (rd_start),
        .rd_abort10     (rd_abort),
        .r_mw10         (r_mw),
        .r_oe_setup10   (r_setup),
        .r_rd_wait10    (r_wait),
        .r_oe_hold10    (r_hold),
        .data_smc10     (data_smc),
        .smc_n_oe10     (n_oe),
        .smc_addr_lsb10 (addr_lsb),
        .rd_data10      (rd_data),
        .rd_valid10     (rd_valid),
        .rd_busy10      (rd_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] mw, input logic [1:0] s, input logic [WS_W-1:0] w,
                       input logic [1:0] h);
        r_mw    = mw;
        r_setup = s;
        r_wait  = w;
        r_hold  = h;
    endtask

    task automatic start_rd(input logic [31:0] expw, input bit push);
        rd_start = 1'b1;
        if (push) exp_q.push_back(expw);
        tick();
        rd_start = 1'b0;
    endtask

    // Scoreboard monitor: every completed word is matched against the queue.
    always @(posedge clk) begin
        #1;
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got %h expected no word", rd_data);
            end else begin
                chk("rd_word", rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; rd_start = 1'b0; rd_abort = 1'b0;
        cfg(2'b10, 2'd0, 4'd1, 2'd0);
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        tick(); tick();
        chkb("rst_oe", n_oe, 1'b1);
        chk("rst_addr", 32'(addr_lsb), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chkb("rst_valid", rd_valid, 1'b0);
        chkb("rst_busy", rd_busy, 1'b0);
        rst = 1'b0;
        tick();

        // 32-bit read, setup=1 wait=2 hold=0
        mem[0] = 32'hDEADBEEF;
        cfg(2'b10, 2'd1, 4'd2, 2'd0);
        start_rd(32'hDEADBEEF, 1'b1);
        chkb("t1_c1_oe", n_oe, 1'b1);
        chkb("t1_c1_busy", rd_busy, 1'b1);
        tick(); chkb("t1_c2_oe", n_oe, 1'b0);
        tick(); chkb("t1_c3_oe", n_oe, 1'b0);
        tick();
        chkb("t1_c4_oe", n_oe, 1'b1);
        chkb("t1_c4_busy", rd_busy, 1'b0);
        chkb("t1_c4_valid", rd_valid, 1'b1);
        tick();

        // 8-bit read, setup=0 wait=1 hold=1
        mem[0] = 32'hFFFFFF11; mem[1] = 32'hEEEEEE22; mem[2] = 32'hDDDDDD33; mem[3] = 32'hCCCCCC44;
        cfg(2'b00, 2'd0, 4'd1, 2'd1);
        start_rd(32'h44332211, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chkb($sformatf("t2_oe_c%0d", i + 1), n_oe, oe_e2[i]);
            chk($sformatf("t2_addr_c%0d", i + 1), 32'(addr_lsb), 32'(ad_e2[i]));
            chkb($sformatf("t2_busy_c%0d", i + 1), rd_busy, (i < 8));
            tick();
        end

        // 16-bit read, wait=0 behaves as 1
        mem[0] = 32'h1234BEEF; mem[1] = 32'h0; mem[2] = 32'h5678CAFE; mem[3] = 32'h0;
        cfg(2'b01, 2'd0, 4'd0, 2'd0);
        start_rd(32'hCAFEBEEF, 1'b1);
        chkb("t3_c1_oe", n_oe, 1'b0);
        chk("t3_c1_addr", 32'(addr_lsb), 32'd0);
        tick();
        chkb("t3_c2_oe", n_oe, 1'b0);
        chk("t3_c2_addr", 32'(addr_lsb), 32'd2);
        tick();
        chkb("t3_c3_oe", n_oe, 1'b1);
        chkb("t3_c3_busy", rd_busy, 1'b0);
        chk("t3_c3_addr", 32'(addr_lsb), 32'd0);
        tick();

        // Abort on the capture cycle of the second 8-bit beat
        mem[0] = 32'h000000AA; mem[1] = 32'h000000BB; mem[2] = 32'h000000CC; mem[3] = 32'h000000DD;
        cfg(2'b00, 2'd0, 4'd2, 2'd0);
        start_rd(32'h0, 1'b0);
        tick(); tick(); tick();
        chk("t4_c4_addr", 32'(addr_lsb), 32'd1);
        rd_abort = 1'b1;
        tick();
        rd_abort = 1'b0;
        chkb("t4_abort_oe", n_oe, 1'b1);
        chkb("t4_abort_busy", rd_busy, 1'b0);
        chkb("t4_abort_valid", rd_valid, 1'b0);
        chk("t4_abort_data", rd_data, 32'h000000AA);
        tick();
        // start together with abort in IDLE: start wins
        cfg(2'b00, 2'd0, 4'd1, 2'd0);
        rd_abort = 1'b1;
        start_rd(32'hDDCCBBAA, 1'b1);
        rd_abort = 1'b0;
        chkb("t4_restart_busy", rd_busy, 1'b1);
        chkb("t4_restart_oe", n_oe, 1'b0);
        tick(); tick(); tick(); tick();
        chkb("t4_done_busy", rd_busy, 1'b0);
        tick();

        // Starts while busy and in the last HOLD cycle are ignored
        mem[0] = 32'h0BADF00D;
        cfg(2'b10, 2'd1, 4'd1, 2'd2);
        start_rd(32'h0BADF00D, 1'b1);
        tick();
        rd_start = 1'b1;
        r_mw = 2'b00;
        tick();
        rd_start = 1'b0;
        chkb("t5_c3_valid", rd_valid, 1'b1);
        chkb("t5_c3_busy", rd_busy, 1'b1);
        tick();
        chkb("t5_c4_busy", rd_busy, 1'b1);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chkb("t5_c5_busy", rd_busy, 1'b0);
        tick();
        chkb("t5_c6_busy", rd_busy, 1'b0);
        tick();

        // Reset while OE is low
        mem[0] = 32'h00000011; mem[1] = 32'h00000022; mem[2] = 32'h00000033; mem[3] = 32'h00000044;
        cfg(2'b00, 2'd0, 4'd1, 2'd0);
        start_rd(32'h0, 1'b0);
        tick();
        chkb("t6_pre_oe", n_oe, 1'b0);
        chk("t6_pre_data", rd_data, 32'h00000011);
        rst = 1'b1;
        tick();
        chkb("t6_rst_oe", n_oe, 1'b1);
        chk("t6_rst_data", rd_data, 32'd0);
        chkb("t6_rst_busy", rd_busy, 1'b0);
        chk("t6_rst_addr", 32'(addr_lsb), 32'd0);
        rst = 1'b0;
        tick();
        mem[0] = 32'hDEADBEEF;
        cfg(2'b10, 2'd1, 4'd2, 2'd0);
        start_rd(32'hDEADBEEF, 1'b1);
        chkb("t6_c1_oe", n_oe, 1'b1);
        tick(); chkb("t6_c2_oe", n_oe, 1'b0);
        tick(); chkb("t6_c3_oe", n_oe, 1'b0);
        tick();
        chkb("t6_c4_valid", rd_valid, 1'b1);
        chkb("t6_c4_busy", rd_busy, 1'b0);

        tick(); tick(); tick();
        chk("pending_words", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
